// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start, DATA_BITS payload LSB first,
// optional odd/even parity, one or two stop bits; ready/done handshake.
module uart_tx_cfg #(
    parameter int CLK_FREQ  = 12_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 tx_start,
    output logic                 tx_out,
    output logic                 tx_ready,
    output logic                 tx_done
);

    localparam int DIVISOR = CLK_FREQ / BAUD;
    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIVISOR - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 rdy_q, rdy_d;
    logic                 done_q, done_d;
    logic                 tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        rdy_d   = rdy_q;
        done_d  = 1'b0;
        tick    = (cnt_q == CNT_MAX);
        cnt_d   = tick ? '0 : cnt_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (tx_start) begin
                    shift_d = data_in;
                    par_d   = (PARITY == 1) ? ~^data_in : ^data_in;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    rdy_d   = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        rdy_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tx_out   = tx_q;
    assign tx_ready = rdy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four configurations at DIVISOR=16,
// frames checked bit by bit against hand-derived line sequences.
module tb_uart_tx_cfg;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din_a;
    logic [6:0] din_b, din_c;
    logic [8:0] din_d;
    logic       st[4];
    logic       tx_o[4];
    logic       rdy_o[4];
    logic       done_o[4];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .reset(reset), .data_in(din_a), .tx_start(st[0]),
        .tx_out(tx_o[0]), .tx_ready(rdy_o[0]), .tx_done(done_o[0]));

    uart_tx_cfg #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(7),
                  .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .reset(reset), .data_in(din_b), .tx_start(st[1]),
        .tx_out(tx_o[1]), .tx_ready(rdy_o[1]), .tx_done(done_o[1]));

    uart_tx_cfg #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(7),
                  .PARITY(1), .STOP_BITS(2)) u_c (
        .clk(clk), .reset(reset), .data_in(din_c), .tx_start(st[2]),
        .tx_out(tx_o[2]), .tx_ready(rdy_o[2]), .tx_done(done_o[2]));

    uart_tx_cfg #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(9),
                  .PARITY(1), .STOP_BITS(1)) u_d (
        .clk(clk), .reset(reset), .data_in(din_d), .tx_start(st[3]),
        .tx_out(tx_o[3]), .tx_ready(rdy_o[3]), .tx_done(done_o[3]));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_din(input int idx, input logic [8:0] d);
        case (idx)
            0: din_a = d[7:0];
            1: din_b = d[6:0];
            2: din_c = d[6:0];
            default: din_d = d;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse tx_start for one edge; returns at #1 after the accept edge.
    task automatic kick(input int idx, input logic [8:0] d, input bit hold);
        set_din(idx, d);
        st[idx] = 1'b1;
        step();
        if (!hold) st[idx] = 1'b0;
    endtask

    // Entered at #1 after the accept edge; leaves at #1 after the
    // edge where tx_ready rises. glitch injects busy-time requests.
    task automatic run_frame(input int idx, input logic [8:0] d,
                             input int nb, input bit has_par,
                             input logic pbit, input int ns,
                             input bit glitch, input string tag);
        logic seq[16];
        int   n, good, hs, g;
        n = 0;
        seq[n++] = 1'b0;
        for (int i = 0; i < nb; i++) seq[n++] = d[i];
        if (has_par) seq[n++] = pbit;
        for (int i = 0; i < ns; i++) seq[n++] = 1'b1;
        hs = 0;
        g  = 0;
        for (int b = 0; b < n; b++) begin
            good = 0;
            for (int c = 0; c < DIV; c++) begin
                if (glitch && (g == 20 || g == 40)) begin
                    st[idx] = 1'b1;
                    set_din(idx, 9'h03C);
                end else if (glitch && (g == 21 || g == 41)) begin
                    st[idx] = 1'b0;
                end
                if (tx_o[idx] === seq[b]) good++;
                if (rdy_o[idx] !== 1'b0 || done_o[idx] !== 1'b0) hs++;
                g++;
                step();
            end
            chk($sformatf("%s bit%0d", tag, b), good, DIV);
        end
        chk({tag, " busy handshake"}, hs, 0);
        chk({tag, " end ready"}, rdy_o[idx], 1'b1);
        chk({tag, " end done"}, done_o[idx], 1'b1);
        chk({tag, " end line"}, tx_o[idx], 1'b1);
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        din_a = '0; din_b = '0; din_c = '0; din_d = '0;
        for (int i = 0; i < 4; i++) st[i] = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst tx%0d", i), tx_o[i], 1'b1);
            chk($sformatf("rst ready%0d", i), rdy_o[i], 1'b1);
            chk($sformatf("rst done%0d", i), done_o[i], 1'b0);
        end
        step();

        // 8N1 0xA5: line 0,1,0,1,0,0,1,0,1,1
        kick(0, 9'h0A5, 1'b0);
        run_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b0, "a5");
        step();
        chk("a5 done drop", done_o[0], 1'b0);
        chk("a5 idle ready", rdy_o[0], 1'b1);

        // 7E2 0x53 (four ones): parity 0, 176 clocks
        kick(1, 9'h053, 1'b0);
        run_frame(1, 9'h053, 7, 1'b1, 1'b0, 2, 1'b0, "7e2");
        step();
        chk("7e2 done drop", done_o[1], 1'b0);

        // 7O2 0x53: parity 1
        kick(2, 9'h053, 1'b0);
        run_frame(2, 9'h053, 7, 1'b1, 1'b1, 2, 1'b0, "7o2");
        step();
        chk("7o2 done drop", done_o[2], 1'b0);

        // Back-to-back with tx_start held: 0x00 then 0xFF
        kick(0, 9'h000, 1'b1);
        set_din(0, 9'h0FF);
        run_frame(0, 9'h000, 8, 1'b0, 1'b0, 1, 1'b0, "b2b0");
        step();
        st[0] = 1'b0;
        chk("b2b gap fall", tx_o[0], 1'b0);
        chk("b2b reaccept ready", rdy_o[0], 1'b0);
        chk("b2b done one cycle", done_o[0], 1'b0);
        run_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 1'b0, "b2b1");
        step();
        chk("b2b1 done drop", done_o[0], 1'b0);

        // Busy-time requests with new data are ignored
        kick(0, 9'h081, 1'b0);
        run_frame(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b1, "ign");
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tx_o[0] !== 1'b1 || rdy_o[0] !== 1'b1 ||
                done_o[0] !== 1'b0) bad++;
        end
        chk("ign no second frame", bad, 0);

        // Reset mid-frame aborts without tx_done
        kick(0, 9'h05A, 1'b0);
        repeat (49) step();
        chk("abort mid busy", rdy_o[0], 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort tx", tx_o[0], 1'b1);
        chk("abort ready", rdy_o[0], 1'b1);
        chk("abort done", done_o[0], 1'b0);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (done_o[0] !== 1'b0 || tx_o[0] !== 1'b1) bad++;
        end
        chk("abort quiet", bad, 0);
        kick(0, 9'h05A, 1'b0);
        run_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b0, "post");
        step();

        // 9O1 0x1FF (nine ones): parity 0, 192 clocks
        kick(3, 9'h1FF, 1'b0);
        run_frame(3, 9'h1FF, 9, 1'b1, 1'b0, 1, 1'b0, "9o1");
        step();
        chk("9o1 done drop", done_o[3], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the VSDSquadron designs.
- Configurable data width, parity mode and stop-bit count.
- Latches the payload at frame acceptance.
- Provides a ready/done handshake for a byte source or FIFO.
- Drives the board TX pin directly; line idles high.

Parameters:
CLK_FREQ, 12_000_000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; DIVISOR = CLK_FREQ/BAUD (integer division) clocks per bit, DIVISOR >= 2
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits per frame, legal 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
data_in  input  DATA_BITS  payload, sampled only on the accept cycle
tx_start  input  1  frame request; level-sampled
tx_out  output  1  serial line, LSB first, registered
tx_ready  output  1  high when idle and able to accept tx_start, registered
tx_done  output  1  one-cycle pulse when a frame's last stop bit completes, registered

Behaviour:
- Reset (sampled on clk edge):
  - Outputs: tx_out=1, tx_ready=1, tx_done=0.
  - Internal state: state=IDLE, baud counter=0, bit index=0, shift register cleared.
- States: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY=0.
- Accept: in IDLE with tx_start=1 on edge k:
  - data_in is latched into the shift register.
  - Parity bit is computed from the latched value.
  - state goes to START; tx_ready=0 and tx_out=0 from edge k onward.
- Bit timing:
  - Every bit (start, each data bit, parity, each stop bit) holds tx_out constant for exactly DIVISOR clocks.
  - Baud counter runs 0..DIVISOR-1 and wraps to 0 at each bit boundary.
  - Counter width is clog2(DIVISOR).
- START -> DATA after DIVISOR clocks. tx_out = latched bit 0.
- DATA:
  - Shifts out bits 0..DATA_BITS-1, LSB first.
  - After bit DATA_BITS-1: go to PARITY, or to STOP if PARITY=0.
- PARITY bit value:
  - odd mode: XNOR-reduce of latched data, so ones count including parity is odd.
  - even mode: XOR-reduce of latched data.
- STOP:
  - tx_out=1 for STOP_BITS*DIVISOR clocks, then state returns to IDLE.
  - On the same edge: tx_ready=1 and tx_done=1 for exactly one cycle.
- Frame length:
  - N = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bits.
  - The edge where tx_out falls to the edge where tx_ready rises is exactly N*DIVISOR clocks.
- tx_start while tx_ready=0: ignored, not queued. data_in changes mid-frame have no effect.
- Back-to-back:
  - tx_start held high gives a new accept on the first IDLE cycle, the cycle tx_done=1.
  - The line therefore sees STOP_BITS*DIVISOR+1 high clocks between frames.
- Reset mid-frame: the frame is aborted and reset values apply on that edge. No tx_done pulse.
- Unused shift-register bits above DATA_BITS do not exist; no width truncation of data_in.

Test Plan:
- CLK_FREQ=160, BAUD=10 (DIVISOR=16), 8N1; data_in=0xA5 with tx_start 1-cycle pulse -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each held 16 clocks. tx_ready low for 160 clocks. Single tx_done pulse at the rising edge of tx_ready.
- DATA_BITS=7, PARITY=2 (even), STOP_BITS=2; data_in=0x53 (four ones) -> parity bit 0, two stop bits, frame 11*16=176 clocks. Same with PARITY=1 -> parity bit 1.
- tx_start held high, data_in=0x00 then 0xFF -> two frames. Second start bit falls exactly 17 clocks after the first frame's stop bit begins (1 stop bit). tx_done pulses twice.
- Pulse tx_start and change data_in to 0x3C at clocks 20 and 40 of a 0x81 frame -> transmitted payload remains 0x81. No second frame.
- Assert reset at clock 50 of a frame -> next cycle tx_out=1, tx_ready=1, tx_done stays 0. A new tx_start afterwards produces a correct full frame.
- DATA_BITS=9, PARITY=1; data_in=0x1FF (nine ones) -> parity bit 0; frame 12*16 clocks; bit 8 transmitted = 1.
